// File: rtl/store_pkg.sv
// Shared types for the narrow-store unit: request size encodings, FSM states
// and the alignment rule that decides whether a request is rejected.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WRITE   = 3'd3,
    ERR     = 3'd4
  } state_t;

  function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request and word-memory bundle of the narrow-store unit.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
// mem_rd_data is taken only on the edge where mem_rd_valid is 1 while a read is outstanding.
interface store_narrow_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        misalign_err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rd_valid, mem_rd_data,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misalign_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rd_valid, mem_rd_data,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done, misalign_err
  );
endinterface

// File: rtl/store_lane_merge.sv
// Merges store data into a word read from memory; byte lane order chosen by BIG_ENDIAN.
module store_lane_merge
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  size_t       size_i,
  output logic [31:0] merged_o
);

  localparam logic BE = BIG_ENDIAN;

  always_comb begin
    merged_o = word_i;
    if (size_i == SZ_WORD) begin
      merged_o = data_i;
    end else begin
      // i is the byte address offset inside the word; the slice index maps it to its lane
      for (int i = 0; i < 4; i++) begin
        if (size_i == SZ_BYTE && offset_i == i[1:0]) begin
          merged_o[8*(BE ? 3-i : i) +: 8] = data_i[7:0];
        end
        if (size_i == SZ_HALF && offset_i[1] == i[1]) begin
          merged_o[8*(BE ? 3-i : i) +: 8] = (i[0] != BE) ? data_i[15:8] : data_i[7:0];
        end
      end
    end
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Byte/half/word store unit over a word-only memory: narrow stores do a
// read-modify-write, misaligned or reserved-size requests are rejected.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic        done,
  output logic        misalign_err,
  output state_t      dbg_state
);

  state_t      state_q;
  logic [31:0] addr_q, data_q, rdata_q, mem_addr_q;
  size_t       size_q;
  logic        rd_en_q, wr_en_q, done_q, err_q;
  logic [31:0] merged;

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .word_i  (rdata_q),
    .data_i  (data_q),
    .offset_i(addr_q[1:0]),
    .size_i  (size_q),
    .merged_o(merged)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= SZ_BYTE;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // strobes and address live for exactly one cycle unless re-armed below
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            data_q <= req_data;
            size_q <= size_t'(req_size);
            if (is_misaligned(size_t'(req_size), req_addr[1:0])) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else if (size_t'(req_size) == SZ_WORD) begin
              state_q    <= WRITE;
              wr_en_q    <= 1'b1;
              done_q     <= 1'b1;
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end else begin
              state_q    <= RD_REQ;
              rd_en_q    <= 1'b1;
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        RD_REQ:  state_q <= RD_WAIT;
        RD_WAIT: begin
          if (mem_rd_valid) begin
            rdata_q    <= mem_rd_data;
            state_q    <= WRITE;
            wr_en_q    <= 1'b1;
            done_q     <= 1'b1;
            mem_addr_q <= {addr_q[31:2], 2'b00};
          end
        end
        WRITE:   state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_addr     = mem_addr_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_wr_data  = (state_q == WRITE) ? merged : 32'h0;
  assign done         = done_q;
  assign misalign_err = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: big- and little-endian instances,
// expected memory events queued at issue time and checked by a negedge monitor.
module tb_store_narrow_unit;
  import store_pkg::*;

  localparam int W = 82;  // {kind[1:0], cycle[15:0], addr[31:0], data[31:0]}
  localparam logic [1:0] K_RD = 2'd1, K_WR = 2'd2, K_ERR = 2'd3;
  localparam logic [1:0] P_READY = 2'd0, P_DRAIN = 2'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_be_q[$];
  logic [W-1:0] exp_le_q[$];
  logic [35:0]  probe_q[$];  // {dut, kind[1:0], pad, expected[31:0]}

  state_t state_be, state_le;

  store_narrow_unit_if bus_be ();
  store_narrow_unit_if bus_le ();

  store_narrow_unit #(.BIG_ENDIAN(1'b1)) dut_be (
    .Clk(clk), .Rst(rst_n),
    .req_valid(bus_be.req_valid), .req_ready(bus_be.req_ready),
    .req_addr(bus_be.req_addr), .req_data(bus_be.req_data), .req_size(bus_be.req_size),
    .mem_addr(bus_be.mem_addr), .mem_rd_en(bus_be.mem_rd_en),
    .mem_rd_valid(bus_be.mem_rd_valid), .mem_rd_data(bus_be.mem_rd_data),
    .mem_wr_en(bus_be.mem_wr_en), .mem_wr_data(bus_be.mem_wr_data),
    .done(bus_be.done), .misalign_err(bus_be.misalign_err), .dbg_state(state_be)
  );

  store_narrow_unit #(.BIG_ENDIAN(1'b0)) dut_le (
    .Clk(clk), .Rst(rst_n),
    .req_valid(bus_le.req_valid), .req_ready(bus_le.req_ready),
    .req_addr(bus_le.req_addr), .req_data(bus_le.req_data), .req_size(bus_le.req_size),
    .mem_addr(bus_le.mem_addr), .mem_rd_en(bus_le.mem_rd_en),
    .mem_rd_valid(bus_le.mem_rd_valid), .mem_rd_data(bus_le.mem_rd_data),
    .mem_wr_en(bus_le.mem_wr_en), .mem_wr_data(bus_le.mem_wr_data),
    .done(bus_le.done), .misalign_err(bus_le.misalign_err), .dbg_state(state_le)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitor ----------------
  function automatic int q_size(input bit d);
    return d ? exp_le_q.size() : exp_be_q.size();
  endfunction

  function automatic logic [W-1:0] q_front(input bit d);
    return d ? exp_le_q[0] : exp_be_q[0];
  endfunction

  task automatic q_pop(input bit d, output logic [W-1:0] e);
    if (d) e = exp_le_q.pop_front();
    else   e = exp_be_q.pop_front();
  endtask

  task automatic mon_dut(input bit d, input logic rd_en, wr_en, err, dn,
                         input logic [31:0] addr, wdata, input state_t st);
    logic [W-1:0] act, exp;
    logic [1:0]   kind;
    if (rd_en | wr_en | err) begin
      kind = {wr_en | err, rd_en | err};
      act  = {kind, cyc[15:0], addr, (wr_en ? wdata : 32'h0)};
      checks++;
      if (q_size(d) == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected event: got k=%0d c=%0d a=%h d=%h st=%0d, required none",
                 d, kind, cyc, addr, act[31:0], st);
      end else begin
        q_pop(d, exp);
        if (act !== exp) begin
          errors++;
          $display("FAIL dut%0d event: got k=%0d c=%0d a=%h d=%h, required k=%0d c=%0d a=%h d=%h",
                   d, act[81:80], act[79:64], act[63:32], act[31:0],
                   exp[81:80], exp[79:64], exp[63:32], exp[31:0]);
        end
      end
      checks++;
      if (dn !== wr_en) begin
        errors++;
        $display("FAIL dut%0d done_vs_wr: got done=%b, required %b at c=%0d", d, dn, wr_en, cyc);
      end
    end else begin
      if (q_size(d) > 0 && q_front(d)[79:64] < cyc[15:0]) begin
        q_pop(d, exp);
        checks++;
        errors++;
        $display("FAIL dut%0d missing event: got none at c=%0d, required k=%0d c=%0d a=%h d=%h",
                 d, cyc, exp[81:80], exp[79:64], exp[63:32], exp[31:0]);
      end
      checks++;
      if ({dn, addr} !== 33'h0) begin
        errors++;
        $display("FAIL dut%0d quiet: got done=%b mem_addr=%h, required 0/0 at c=%0d st=%0d",
                 d, dn, addr, cyc, st);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] p;
    logic [31:0] actual;
    mon_dut(1'b0, bus_be.mem_rd_en, bus_be.mem_wr_en, bus_be.misalign_err, bus_be.done,
            bus_be.mem_addr, bus_be.mem_wr_data, state_be);
    mon_dut(1'b1, bus_le.mem_rd_en, bus_le.mem_wr_en, bus_le.misalign_err, bus_le.done,
            bus_le.mem_addr, bus_le.mem_wr_data, state_le);
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      if (p[34:33] == P_READY) actual = {31'h0, (p[35] ? bus_le.req_ready : bus_be.req_ready)};
      else                     actual = q_size(p[35]);
      checks++;
      if (actual !== p[31:0]) begin
        errors++;
        $display("FAIL dut%0d %s: got %0d, required %0d at c=%0d",
                 p[35], (p[34:33] == P_READY) ? "req_ready" : "drain", actual, p[31:0], cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ready(input bit d);
    return d ? bus_le.req_ready : bus_be.req_ready;
  endfunction

  task automatic drive_req(input bit d, input logic v, input logic [31:0] a, dt, input logic [1:0] s);
    if (d) begin
      bus_le.req_valid = v; bus_le.req_addr = a; bus_le.req_data = dt; bus_le.req_size = s;
    end else begin
      bus_be.req_valid = v; bus_be.req_addr = a; bus_be.req_data = dt; bus_be.req_size = s;
    end
  endtask

  task automatic drive_mem(input bit d, input logic v, input logic [31:0] rdat);
    if (d) begin bus_le.mem_rd_valid = v; bus_le.mem_rd_data = rdat; end
    else   begin bus_be.mem_rd_valid = v; bus_be.mem_rd_data = rdat; end
  endtask

  task automatic probe_ready(input bit d, input logic e);
    probe_q.push_back({d, P_READY, 1'b0, 31'h0, e});
  endtask

  task automatic expect_ev(input bit d, input logic [1:0] k, input int c, input logic [31:0] a, dt);
    if (d) exp_le_q.push_back({k, c[15:0], a, dt});
    else   exp_be_q.push_back({k, c[15:0], a, dt});
  endtask

  // bounded wait for acceptance; a stuck-low ready is reported by the monitor
  task automatic wait_ready(input bit d, output int acc);
    for (int k = 0; k < 20 && !get_ready(d); k++) step();
    if (!get_ready(d)) probe_ready(d, 1'b1);
    acc = cyc;
  endtask

  task automatic issue(input bit d, input logic [31:0] a, dt, input logic [1:0] s, output int acc);
    drive_req(d, 1'b1, a, dt, s);
    wait_ready(d, acc);
  endtask

  // narrow store: junk on the request bus and a stray read-valid during RD_REQ must be ignored
  task automatic rmw(input bit d, input logic [31:0] a, dt, input logic [1:0] s,
                     input logic [31:0] rword, wword, input int lat);
    int acc;
    issue(d, a, dt, s, acc);
    expect_ev(d, K_RD, acc + 1, {a[31:2], 2'b00}, 32'h0);
    step();
    drive_req(d, 1'b0, ~a, ~dt, SZ_WORD);
    drive_mem(d, 1'b1, 32'hFFFF_FFFF);
    step();
    drive_mem(d, 1'b0, 32'h0);
    repeat (lat) step();
    drive_mem(d, 1'b1, rword);
    expect_ev(d, K_WR, cyc + 1, {a[31:2], 2'b00}, wword);
    step();
    drive_mem(d, 1'b0, 32'h0);
    probe_ready(d, 1'b0);
    step();
    probe_ready(d, 1'b1);
  endtask

  task automatic bad(input logic [31:0] a, input logic [1:0] s);
    int acc;
    issue(1'b0, a, 32'h5A5A_5A5A, s, acc);
    expect_ev(1'b0, K_ERR, acc + 1, 32'h0, 32'h0);
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_BYTE);
    probe_ready(1'b0, 1'b0);
    step();
    probe_ready(1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_BYTE);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, SZ_BYTE);
    drive_mem(1'b0, 1'b0, 32'h0);
    drive_mem(1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    probe_ready(1'b0, 1'b1);
    probe_ready(1'b1, 1'b1);

    // read-valid while idle is ignored
    drive_mem(1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive_mem(1'b0, 1'b0, 32'h0);

    // aligned word store
    issue(1'b0, 32'h100, 32'hDEAD_BEEF, SZ_WORD, acc);
    expect_ev(1'b0, K_WR, acc + 1, 32'h100, 32'hDEAD_BEEF);
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h1234_5678, SZ_BYTE);
    probe_ready(1'b0, 1'b0);
    step();
    probe_ready(1'b0, 1'b1);

    // read-modify-write stores, both lane orders
    rmw(1'b0, 32'h203, 32'h0000_00AB, SZ_BYTE, 32'h1122_3344, 32'h1122_33AB, 1);
    rmw(1'b0, 32'h202, 32'h0000_CAFE, SZ_HALF, 32'h1122_3344, 32'h1122_CAFE, 0);
    rmw(1'b1, 32'h202, 32'h0000_CAFE, SZ_HALF, 32'h1122_3344, 32'hCAFE_3344, 0);
    rmw(1'b1, 32'h203, 32'h0000_00AB, SZ_BYTE, 32'h1122_3344, 32'hAB22_3344, 2);
    rmw(1'b0, 32'h200, 32'hFFFF_55AA, SZ_HALF, 32'h1122_3344, 32'h55AA_3344, 3);
    rmw(1'b0, 32'h200, 32'h1234_56AB, SZ_BYTE, 32'h1122_3344, 32'hAB22_3344, 0);
    rmw(1'b1, 32'h201, 32'h0000_0077, SZ_BYTE, 32'h1122_3344, 32'h1122_7744, 1);
    rmw(1'b1, 32'h200, 32'h0000_BEEF, SZ_HALF, 32'hAAAA_AAAA, 32'hAAAA_BEEF, 0);

    // rejected requests
    bad(32'h301, SZ_HALF);
    bad(32'h302, SZ_WORD);
    bad(32'h300, SZ_RSVD);

    // reset while waiting for read data; late read-valid must not cause a write
    issue(1'b0, 32'h101, 32'h0000_0055, SZ_BYTE, acc);
    expect_ev(1'b0, K_RD, acc + 1, 32'h100, 32'h0);
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_BYTE);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    probe_ready(1'b0, 1'b1);
    step();
    drive_mem(1'b0, 1'b1, 32'h9999_9999);
    probe_ready(1'b0, 1'b1);
    step();
    drive_mem(1'b0, 1'b0, 32'h0);
    repeat (3) step();

    // back-to-back words with valid held high and data changed after each acceptance
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 1'b1, 32'h400 + 4 * i, 32'h1111_1111 * (i + 1), SZ_WORD);
      wait_ready(1'b0, acc);
      expect_ev(1'b0, K_WR, acc + 1, 32'h400 + 4 * i, 32'h1111_1111 * (i + 1));
      step();
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_BYTE);
    repeat (3) step();

    probe_q.push_back({1'b0, P_DRAIN, 1'b0, 32'h0});
    probe_q.push_back({1'b1, P_DRAIN, 1'b0, 32'h0});
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1: byte lane order; 1 puts addr[1:0]=0 at bits 31:24, 0 puts it at bits 7:0.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: store request present.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port req_addr, input, 32: byte address.
REQ-007 SHALL have port req_data, input, 32: store data; the value is in the low bits for byte and half stores.
REQ-008 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port mem_addr, output, 32: word address, with bits [1:0] always 0.
REQ-010 SHALL have port mem_rd_en, output, 1: one-cycle read strobe.
REQ-011 SHALL have port mem_rd_valid, input, 1: read data valid; memory latency is 1 or more cycles.
REQ-012 SHALL have port mem_rd_data, input, 32: read word.
REQ-013 SHALL have port mem_wr_en, output, 1: one-cycle write strobe; memory writes whole words only.
REQ-014 SHALL have port mem_wr_data, output, 32: word to write.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a store completes.
REQ-016 SHALL have port misalign_err, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-017 SHALL accept a request on a cycle where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in state IDLE.
REQ-018 SHALL register addr, data and size at acceptance; later changes on the request inputs SHALL have no effect.
REQ-019 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, WRITE, ERR.
- IDLE to WRITE: accepted aligned word.
- IDLE to RD_REQ: accepted aligned byte or half.
- IDLE to ERR: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- RD_REQ to RD_WAIT: after one cycle.
- RD_WAIT to WRITE: on mem_rd_valid.
- WRITE to IDLE and ERR to IDLE: after one cycle.
REQ-020 SHALL assert mem_rd_en for exactly the one cycle spent in RD_REQ, with mem_addr = {addr[31:2],2'b00}.
REQ-021 SHALL ignore mem_rd_valid in every state except RD_WAIT.
REQ-022 SHALL capture mem_rd_data on the RD_WAIT cycle where mem_rd_valid=1.
REQ-023 SHALL, in WRITE, assert mem_wr_en and done together for one cycle with mem_wr_data set as follows:
- word: req_data unchanged.
- byte: the captured word with lane addr[1:0] replaced by data[7:0].
- half: the captured word with lanes addr[1], addr[1]+1 replaced by data[15:0].
- Lane order SHALL follow BIG_ENDIAN.
REQ-024 SHALL make no memory access in ERR and SHALL pulse misalign_err for that cycle.
REQ-025 SHALL meet these latencies with acceptance at cycle N:
- word: write and done at N+1.
- byte or half: mem_rd_en at N+1; with mem_rd_valid at cycle M (M≥N+2), write and done at M+1.
- error: misalign_err at N+1.
- The earliest next acceptance SHALL be the cycle after WRITE or ERR.
REQ-026 SHALL wait in RD_WAIT with no timeout.
REQ-027 SHALL hold mem_addr at 0 whenever mem_rd_en=0 and mem_wr_en=0.

Reset
REQ-028 SHALL, on a rising Clk edge with Rst=0, go to IDLE and set mem_rd_en, mem_wr_en, done, misalign_err, mem_addr, mem_wr_data and all captured registers to 0.
REQ-029 SHALL have req_ready=1 on the first cycle after Rst is released.
REQ-030 SHALL, if reset arrives mid-operation in any state, issue no write, and SHALL discard any mem_rd_valid that arrives after reset.

Structure
REQ-031 SHALL define in shared package store_pkg: size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD, and the FSM state type.
REQ-032 SHALL place the lane merge logic (captured word, data, offset, size, BIG_ENDIAN in; merged word out) in combinational sub-module store_lane_merge.

Verification
REQ-033 Word store, addr 0x100, data 0xDEADBEEF, accepted cycle N -> mem_wr_en at N+1 with mem_addr 0x100, mem_wr_data 0xDEADBEEF; done at N+1; no mem_rd_en.
REQ-034 Byte store, addr 0x203, data 0x000000AB, memory returns 0x11223344 after 3 cycles, BIG_ENDIAN=1 -> mem_rd_en one cycle at 0x200; write 0x112233AB one cycle after valid.
REQ-035 Half store, addr 0x202, data 0x0000CAFE, memory returns 0x11223344 -> BIG_ENDIAN=1 writes 0x1122CAFE; BIG_ENDIAN=0 writes 0xCAFE3344.
REQ-036 Misaligned requests: half at 0x301, word at 0x302, size 11 -> misalign_err one cycle after each; mem_rd_en and mem_wr_en stay 0; req_ready returns the following cycle.
REQ-037 Byte store, then Rst=0 during RD_WAIT, then mem_rd_valid after reset release -> no mem_wr_en, no done, req_ready=1.
REQ-038 Back-to-back word stores with req_valid held high and data changed after acceptance -> one write per accepted request, each carrying the data captured at its acceptance.
